// File: rtl/fp_add_share_arbiter.sv
// Shared floating-point adder: round-robin arbitration among NUM_REQ requesters
// into a two-stage pipeline (operand register, adder, result register).
// Results leave on one tagged response channel, and the block keeps sticky
// exception flags.
// Round mode encoding: 00 nearest-even, 01 toward zero, 10 down, 11 up.
// Exception bits: [4] invalid, [3] divide-by-zero, [2] overflow,
// [1] underflow, [0] inexact.

module FloatingPointAdd #(
    parameter int EXP_WIDTH  = 8,
    parameter int FRAC_WIDTH = 23,
    localparam int W = EXP_WIDTH + FRAC_WIDTH + 1
) (
    input  logic [W-1:0] op1,
    input  logic [W-1:0] op2,
    input  logic [1:0]   round_mode,
    output logic [W-1:0] result,
    output logic [4:0]   exception
);
    localparam int E    = EXP_WIDTH;
    localparam int F    = FRAC_WIDTH;
    localparam int X    = F + 4;          // hidden + fraction + guard/round/sticky
    localparam int EMAX = (1 << E) - 1;

    function automatic int lead_zeros(input logic [X-1:0] v);
        int n;
        n = X;
        for (int i = 0; i < X; i++) if (v[i]) n = X - 1 - i;
        return n;
    endfunction

    logic           op1_nan, op2_nan, op1_snan, op2_snan, op1_inf, op2_inf;
    logic           sub, sign_r, sticky, rnd_up, inexact, ovf, unf, to_inf;
    logic [W-1:0]   big, sml;
    logic [E-1:0]   eb, es;
    logic [X-1:0]   mb, ms, ms_sh, mask, norm;
    logic [X:0]     sum;
    logic [F+1:0]   mr;
    logic [F-1:0]   frac;
    int             d, lz, sh, ex, ef;

    assign op1_nan  = (&op1[W-2:F]) && (|op1[F-1:0]);
    assign op2_nan  = (&op2[W-2:F]) && (|op2[F-1:0]);
    assign op1_snan = op1_nan && !op1[F-1];
    assign op2_snan = op2_nan && !op2[F-1];
    assign op1_inf  = (&op1[W-2:F]) && !(|op1[F-1:0]);
    assign op2_inf  = (&op2[W-2:F]) && !(|op2[F-1:0]);

    // Align the smaller magnitude, add/subtract, normalise, round, then apply specials.
    always_comb begin
        result = '0; exception = '0;
        lz = 0; sh = 0; ovf = 1'b0; sticky = 1'b0;
        big  = (op1[W-2:0] >= op2[W-2:0]) ? op1 : op2;
        sml  = (op1[W-2:0] >= op2[W-2:0]) ? op2 : op1;
        sub  = big[W-1] ^ sml[W-1];
        eb   = (big[W-2:F] == '0) ? E'(1) : big[W-2:F];
        es   = (sml[W-2:F] == '0) ? E'(1) : sml[W-2:F];
        d    = int'(eb) - int'(es);
        mb   = {|big[W-2:F], big[F-1:0], 3'b000};
        ms   = {|sml[W-2:F], sml[F-1:0], 3'b000};
        mask = ~({X{1'b1}} << d);
        if (d >= X) begin
            ms_sh  = '0;
            sticky = |ms;
        end else begin
            ms_sh  = ms >> d;
            sticky = |(ms & mask);
        end
        ms_sh[0] = ms_sh[0] | sticky;
        sum = sub ? ({1'b0, mb} - {1'b0, ms_sh}) : ({1'b0, mb} + {1'b0, ms_sh});
        ex  = int'(eb);
        if (sum[X]) begin
            norm = {sum[X:2], |sum[1:0]};
            ex   = ex + 1;
        end else begin
            lz   = lead_zeros(sum[X-1:0]);
            sh   = (lz < ex - 1) ? lz : ex - 1;
            norm = sum[X-1:0] << sh;
            ex   = ex - sh;
        end
        // An exact zero from cancellation is +0 except when rounding down.
        sign_r  = (sub && sum == '0) ? (round_mode == 2'b10) : big[W-1];
        inexact = |norm[2:0];
        unique case (round_mode)
            2'b00:   rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
            2'b01:   rnd_up = 1'b0;
            2'b10:   rnd_up = inexact & sign_r;
            default: rnd_up = inexact & !sign_r;
        endcase
        unf = !norm[X-1] && inexact;
        mr  = {1'b0, norm[X-1:3]} + {{(F+1){1'b0}}, rnd_up};
        if (mr[F+1]) begin
            ef   = ex + 1;
            frac = mr[F:1];
        end else begin
            ef   = mr[F] ? ex : 0;
            frac = mr[F-1:0];
        end
        to_inf = (round_mode == 2'b00) || (round_mode == 2'b10 && sign_r) ||
                 (round_mode == 2'b11 && !sign_r);
        if (ef >= EMAX) begin
            ovf    = 1'b1;
            result = to_inf ? {sign_r, {E{1'b1}}, {F{1'b0}}}
                            : {sign_r, {(E-1){1'b1}}, 1'b0, {F{1'b1}}};
        end else begin
            result = {sign_r, E'(ef), frac};
        end
        exception = {2'b00, ovf, unf, inexact | ovf};
        // Default NaN is negative quiet with only the top fraction bit set.
        if (op1_nan || op2_nan) begin
            result    = {1'b1, {E{1'b1}}, 1'b1, {(F-1){1'b0}}};
            exception = {op1_snan | op2_snan, 4'b0000};
        end else if (op1_inf && op2_inf && (op1[W-1] != op2[W-1])) begin
            result    = {1'b1, {E{1'b1}}, 1'b1, {(F-1){1'b0}}};
            exception = 5'b10000;
        end else if (op1_inf || op2_inf) begin
            result    = op1_inf ? op1 : op2;
            exception = '0;
        end
    end
endmodule

module fp_add_share_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int EXP_WIDTH  = 8,
    parameter int FRAC_WIDTH = 23,
    localparam int W   = EXP_WIDTH + FRAC_WIDTH + 1,
    localparam int IDW = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*W-1:0] req_op1,
    input  logic [NUM_REQ*W-1:0] req_op2,
    input  logic [NUM_REQ*2-1:0] req_round_mode,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IDW-1:0]       resp_id,
    output logic [W-1:0]         resp_result,
    output logic [4:0]           resp_exception,
    output logic [4:0]           exc_sticky,
    input  logic                 exc_clear
);
    logic           s1_valid, s1_adv, s1_free, s2_free, grant, grant_found, resp_hs;
    logic [W-1:0]   s1_op1, s1_op2, add_result;
    logic [1:0]     s1_rm;
    logic [IDW-1:0] s1_id, rr_ptr, grant_idx, scan_idx;
    logic [4:0]     add_exc;
    int             scan;

    assign s2_free = !resp_valid || resp_ready;
    assign s1_adv  = s1_valid && s2_free;
    assign s1_free = !s1_valid || s1_adv;
    assign resp_hs = resp_valid && resp_ready;

    // First valid requester at or after rr_ptr, wrapping to 0.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan        = 0;
        scan_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan = int'(rr_ptr) + i;
            if (scan >= NUM_REQ) scan = scan - NUM_REQ;
            scan_idx = IDW'(scan);
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    // Reset also masks the grant so nothing is offered while the pipe is held clear.
    assign req_ready = (rst_n && s1_free && grant_found)
                       ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx) : '0;
    assign grant     = |req_ready;

    // Round-robin pointer moves just past the granted requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_ptr <= '0;
        else if (grant)
            rr_ptr <= (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end

    // Operand stage: capture on grant, otherwise empty when it advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op1   <= '0;
            s1_op2   <= '0;
            s1_rm    <= '0;
            s1_id    <= '0;
        end else if (grant) begin
            s1_valid <= 1'b1;
            s1_op1   <= req_op1[grant_idx*W +: W];
            s1_op2   <= req_op2[grant_idx*W +: W];
            s1_rm    <= req_round_mode[grant_idx*2 +: 2];
            s1_id    <= grant_idx;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    FloatingPointAdd #(.EXP_WIDTH(EXP_WIDTH), .FRAC_WIDTH(FRAC_WIDTH)) u_add (
        .op1        (s1_op1),
        .op2        (s1_op2),
        .round_mode (s1_rm),
        .result     (add_result),
        .exception  (add_exc)
    );

    // Result stage: holds its data until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid     <= 1'b0;
            resp_result    <= '0;
            resp_exception <= '0;
            resp_id        <= '0;
        end else if (s1_adv) begin
            resp_valid     <= 1'b1;
            resp_result    <= add_result;
            resp_exception <= add_exc;
            resp_id        <= s1_id;
        end else if (resp_ready) begin
            resp_valid     <= 1'b0;
        end
    end

    // Sticky flags; a clear coinciding with a delivery keeps only the new flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            exc_sticky <= '0;
        else if (exc_clear)
            exc_sticky <= resp_hs ? resp_exception : '0;
        else if (resp_hs)
            exc_sticky <= exc_sticky | resp_exception;
    end
endmodule

// File: tb/tb_fp_add_share_arbiter.sv
// Directed bench for the shared floating-point adder arbiter.
module tb_fp_add_share_arbiter;
    localparam int N = 4;
    localparam int W = 32;
    localparam logic [4:0] EX_NONE = 5'b00000;
    localparam logic [4:0] EX_NX   = 5'b00001;
    localparam logic [4:0] EX_OFNX = 5'b00101;
    localparam logic [4:0] EX_NV   = 5'b10000;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid, req_ready;
    logic [N*W-1:0] req_op1, req_op2;
    logic [N*2-1:0] req_round_mode;
    logic           resp_valid, resp_ready, exc_clear;
    logic [1:0]     resp_id;
    logic [W-1:0]   resp_result;
    logic [4:0]     resp_exception, exc_sticky;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] r_res;
    logic [4:0]  r_exc;
    logic [1:0]  r_id;
    bit          r_to;

    always #5 clk = ~clk;

    fp_add_share_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op1(req_op1), .req_op2(req_op2), .req_round_mode(req_round_mode),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_exception(resp_exception),
        .exc_sticky(exc_sticky), .exc_clear(exc_clear)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] rm);
        req_op1[i*W +: W]        = a;
        req_op2[i*W +: W]        = b;
        req_round_mode[i*2 +: 2] = rm;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_valid = '0; resp_ready = 1'b0; exc_clear = 1'b0;
        req_op1 = '0; req_op2 = '0; req_round_mode = '0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    // Push one op through requester idx and capture the delivered response.
    task automatic run_one(input int idx, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] rm, input bit clr,
                           output logic [31:0] res, output logic [4:0] exc,
                           output logic [1:0] id, output bit to);
        int cyc;
        to = 1'b0;
        set_req(idx, a, b, rm);
        req_valid[idx] = 1'b1;
        resp_ready = 1'b1;
        #1;
        cyc = 0;
        while (!req_ready[idx] && cyc < 20) begin tick(); #1; cyc++; end
        if (!req_ready[idx]) to = 1'b1;
        tick();
        req_valid[idx] = 1'b0;
        cyc = 0;
        while (!resp_valid && cyc < 20) begin tick(); cyc++; end
        if (!resp_valid) to = 1'b1;
        res = resp_result; exc = resp_exception; id = resp_id;
        exc_clear = clr;
        tick();
        exc_clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; resp_ready = 1'b1; exc_clear = 1'b0; req_valid = '1;
        req_op1 = '0; req_op2 = '0; req_round_mode = '0;
        #3;
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        n_checks++; if (resp_result !== 32'h0 || resp_id !== 2'd0 || resp_exception !== 5'd0)
            begin n_fail++; $display("FAIL reset_resp_data: got %h/%0d/%b want 0", resp_result, resp_id, resp_exception); end
        n_checks++; if (exc_sticky !== 5'd0) begin n_fail++; $display("FAIL reset_sticky: got %b want 0", exc_sticky); end
        repeat (2) tick();
        n_checks++; if (req_ready !== 4'b0000 || resp_valid !== 1'b0)
            begin n_fail++; $display("FAIL reset_held: ready %b valid %b want 0000/0", req_ready, resp_valid); end
        req_valid = '0;
    endtask

    task automatic test_single_add();
        do_reset();
        set_req(0, 32'h3F800000, 32'h40000000, 2'b00);
        req_valid = 4'b0001; resp_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL t1_grant: got %b want 0001", req_ready); end
        tick();
        req_valid = '0;
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL t1_early_valid: got %b want 0", resp_valid); end
        tick();
        n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL t1_valid: got %b want 1", resp_valid); end
        n_checks++; if (resp_id !== 2'd0) begin n_fail++; $display("FAIL t1_id: got %0d want 0", resp_id); end
        n_checks++; if (resp_result !== 32'h40400000) begin n_fail++; $display("FAIL t1_result: got %h want 40400000", resp_result); end
        n_checks++; if (resp_exception !== EX_NONE) begin n_fail++; $display("FAIL t1_exc: got %b want 00000", resp_exception); end
        tick();
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL t1_drained: got %b want 0", resp_valid); end
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_sum [4];
        exp_sum[0] = 32'h40000000; exp_sum[1] = 32'h40400000;
        exp_sum[2] = 32'h40800000; exp_sum[3] = 32'h40A00000;
        rst_n = 1'b0;
        set_req(0, 32'h3F800000, 32'h3F800000, 2'b00);
        set_req(1, 32'h3F800000, 32'h40000000, 2'b00);
        set_req(2, 32'h3F800000, 32'h40400000, 2'b00);
        set_req(3, 32'h3F800000, 32'h40800000, 2'b00);
        req_valid = '1; resp_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            #1;
            n_checks++; if (req_ready !== (4'b0001 << (k % 4)))
                begin n_fail++; $display("FAIL t2_grant cyc %0d: got %b want %b", k, req_ready, 4'b0001 << (k % 4)); end
            if (k >= 2) begin
                n_checks++; if (resp_valid !== 1'b1 || resp_id !== 2'((k - 2) % 4) || resp_result !== exp_sum[(k - 2) % 4])
                    begin n_fail++; $display("FAIL t2_resp cyc %0d: got v%b id%0d %h want v1 id%0d %h",
                                             k, resp_valid, resp_id, resp_result, (k - 2) % 4, exp_sum[(k - 2) % 4]); end
            end
            tick();
        end
        req_valid = '0;
        repeat (3) tick();
    endtask

    task automatic test_backpressure();
        logic [3:0] acc;
        int accepted;
        do_reset();
        set_req(0, 32'h3F800000, 32'h40000000, 2'b00);
        set_req(1, 32'h3F800000, 32'h40400000, 2'b00);
        set_req(2, 32'h3F800000, 32'h40800000, 2'b00);
        req_valid = 4'b0111; resp_ready = 1'b0; accepted = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            acc = req_ready;
            accepted += $countones(acc);
            n_checks++; if (acc !== ((c == 0) ? 4'b0001 : (c == 1) ? 4'b0010 : 4'b0000))
                begin n_fail++; $display("FAIL t3_grant cyc %0d: got %b", c, acc); end
            if (c >= 2) begin
                n_checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_result !== 32'h40400000)
                    begin n_fail++; $display("FAIL t3_stable cyc %0d: got v%b id%0d %h want v1 id0 40400000", c, resp_valid, resp_id, resp_result); end
            end
            tick();
            req_valid = req_valid & ~acc;
        end
        n_checks++; if (accepted != 2) begin n_fail++; $display("FAIL t3_count: got %0d want 2", accepted); end
        resp_ready = 1'b1;
        #1;
        acc = req_ready;
        n_checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd0 || acc !== 4'b0100)
            begin n_fail++; $display("FAIL t3_release0: got v%b id%0d ready %b want v1 id0 0100", resp_valid, resp_id, acc); end
        tick();
        req_valid = req_valid & ~acc;
        n_checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_result !== 32'h40800000)
            begin n_fail++; $display("FAIL t3_release1: got v%b id%0d %h want v1 id1 40800000", resp_valid, resp_id, resp_result); end
        tick();
        n_checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_result !== 32'h40A00000)
            begin n_fail++; $display("FAIL t3_third: got v%b id%0d %h want v1 id2 40A00000", resp_valid, resp_id, resp_result); end
        tick();
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL t3_empty: got %b want 0", resp_valid); end
    endtask

    task automatic test_exceptions();
        do_reset();
        run_one(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 2'b00, 1'b0, r_res, r_exc, r_id, r_to);
        n_checks++; if (r_to || r_res !== 32'h7F800000 || r_exc !== EX_OFNX)
            begin n_fail++; $display("FAIL t4_overflow: got to%b %h %b want 7F800000 00101", r_to, r_res, r_exc); end
        n_checks++; if (exc_sticky !== EX_OFNX) begin n_fail++; $display("FAIL t4_sticky_set: got %b want 00101", exc_sticky); end
        repeat (3) tick();
        n_checks++; if (exc_sticky !== EX_OFNX) begin n_fail++; $display("FAIL t4_sticky_hold: got %b want 00101", exc_sticky); end
        run_one(1, 32'h3F800000, 32'h30800000, 2'b00, 1'b1, r_res, r_exc, r_id, r_to);
        n_checks++; if (r_to || r_res !== 32'h3F800000 || r_exc !== EX_NX || r_id !== 2'd1)
            begin n_fail++; $display("FAIL t4_inexact: got to%b %h %b id%0d want 3F800000 00001 id1", r_to, r_res, r_exc, r_id); end
        n_checks++; if (exc_sticky !== EX_NX) begin n_fail++; $display("FAIL t4_clear_hs: got %b want 00001", exc_sticky); end
        exc_clear = 1'b1;
        tick();
        exc_clear = 1'b0;
        n_checks++; if (exc_sticky !== EX_NONE) begin n_fail++; $display("FAIL t4_clear: got %b want 00000", exc_sticky); end
        run_one(2, 32'h7F7FFFFF, 32'h7F7FFFFF, 2'b01, 1'b0, r_res, r_exc, r_id, r_to);
        n_checks++; if (r_to || r_res !== 32'h7F7FFFFF || r_exc !== EX_OFNX)
            begin n_fail++; $display("FAIL t4_ovf_rtz: got to%b %h %b want 7F7FFFFF 00101", r_to, r_res, r_exc); end
    endtask

    task automatic test_specials();
        do_reset();
        run_one(3, 32'h7F800000, 32'hFF800000, 2'b00, 1'b0, r_res, r_exc, r_id, r_to);
        n_checks++; if (r_to || r_res !== 32'hFFC00000 || r_exc !== EX_NV || r_id !== 2'd3)
            begin n_fail++; $display("FAIL t5_inf_minus_inf: got to%b %h %b id%0d want FFC00000 10000 id3", r_to, r_res, r_exc, r_id); end
        n_checks++; if (exc_sticky !== EX_NV) begin n_fail++; $display("FAIL t5_sticky: got %b want 10000", exc_sticky); end
        run_one(0, 32'h3F800000, 32'hBF800000, 2'b00, 1'b0, r_res, r_exc, r_id, r_to);
        n_checks++; if (r_to || r_res !== 32'h00000000 || r_exc !== EX_NONE)
            begin n_fail++; $display("FAIL cancel_rne: got to%b %h %b want 00000000 00000", r_to, r_res, r_exc); end
        run_one(1, 32'h3F800000, 32'hBF800000, 2'b10, 1'b0, r_res, r_exc, r_id, r_to);
        n_checks++; if (r_to || r_res !== 32'h80000000 || r_exc !== EX_NONE)
            begin n_fail++; $display("FAIL cancel_rdn: got to%b %h %b want 80000000 00000", r_to, r_res, r_exc); end
        run_one(2, 32'h3F800000, 32'h33800000, 2'b00, 1'b0, r_res, r_exc, r_id, r_to);
        n_checks++; if (r_to || r_res !== 32'h3F800000 || r_exc !== EX_NX)
            begin n_fail++; $display("FAIL tie_rne: got to%b %h %b want 3F800000 00001", r_to, r_res, r_exc); end
        run_one(2, 32'h3F800000, 32'h33800000, 2'b11, 1'b0, r_res, r_exc, r_id, r_to);
        n_checks++; if (r_to || r_res !== 32'h3F800001 || r_exc !== EX_NX)
            begin n_fail++; $display("FAIL tie_rup: got to%b %h %b want 3F800001 00001", r_to, r_res, r_exc); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        set_req(0, 32'h3F800000, 32'h40000000, 2'b00);
        set_req(1, 32'h3F800000, 32'h40400000, 2'b00);
        req_valid = 4'b0011; resp_ready = 1'b0;
        tick();
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b0000;
        n_checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd0)
            begin n_fail++; $display("FAIL t6_full: got v%b id%0d want v1 id0", resp_valid, resp_id); end
        set_req(2, 32'h3F800000, 32'h3F800000, 2'b00);
        set_req(3, 32'h3F800000, 32'h3F800000, 2'b00);
        set_req(0, 32'h3F800000, 32'h3F800000, 2'b00);
        req_valid = 4'b1111;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (resp_valid !== 1'b0 || req_ready !== 4'b0000)
            begin n_fail++; $display("FAIL t6_async: got v%b ready %b want v0 0000", resp_valid, req_ready); end
        tick();
        rst_n = 1'b1;
        resp_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL t6_restart: got %b want 0001", req_ready); end
        tick();
        req_valid = '0;
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL t6_no_stale: got %b want 0", resp_valid); end
        tick();
        n_checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_result !== 32'h40000000)
            begin n_fail++; $display("FAIL t6_new_op: got v%b id%0d %h want v1 id0 40000000", resp_valid, resp_id, resp_result); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_round_robin();
        test_backpressure();
        test_exceptions();
        test_specials();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
